button_to_note: RTL and testbench

- Reverse direction of the note-to-LED display path: converts seven one-hot note buttons plus octave up/down buttons into the 5-bit note code (1..28, 0 = silence) consumed by the tone generator and the LED display.
- Sits between the board pushbuttons and the note bus.
- Synchronizes and debounces every button.
- Tracks the current octave (0..3).
- Emits a registered note code with a one-cycle valid strobe on every change to a sounding note.

---
 rtl/button_to_note.sv | 118 +++++++++++
 tb/tb_button_to_note.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_to_note.sv
// rtl/button_to_note.sv - debounced note/octave buttons to 5-bit note code
module button_to_note #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int DB_CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] key,
  input  logic       oct_up,
  input  logic       oct_dn,
  output logic [4:0] note,
  output logic       note_valid,
  output logic [1:0] octave,
  output logic       key_err
);

  localparam int NIN = 9;
  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NIN-1:0]      raw;
  logic [NIN-1:0]      sync1;
  logic [NIN-1:0]      sync2;
  logic [NIN-1:0]      stable;
  logic [1:0]          oct_prev;
  logic [DB_CNT_W-1:0] db_cnt [NIN];

  logic       up_rise;
  logic       dn_rise;
  logic [1:0] octave_next;
  logic [6:0] k;
  logic       multi;
  logic [4:0] degree;
  logic [4:0] note_next;
  logic       valid_next;

  assign raw = {oct_dn, oct_up, key};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Each input must disagree with its stable value for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_CNT_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) oct_prev <= '0;
    else     oct_prev <= stable[8:7];
  end

  assign up_rise = stable[7] & ~oct_prev[0];
  assign dn_rise = stable[8] & ~oct_prev[1];

  always_comb begin
    octave_next = octave;
    if (up_rise && !dn_rise && octave != 2'd3)
      octave_next = octave + 2'd1;
    else if (dn_rise && !up_rise && octave != 2'd0)
      octave_next = octave - 2'd1;
  end

  // Encode uses the next-state octave so an octave change re-encodes a held key on the same edge.
  assign k     = stable[6:0];
  assign multi = |(k & (k - 7'd1));

  always_comb begin
    degree = '0;
    for (int i = 0; i < 7; i++) begin
      if (k[i]) degree = 5'(i + 1);
    end
  end

  always_comb begin
    note_next = '0;
    if (k != 7'd0 && !multi)
      note_next = ({3'b000, octave_next} * 5'd7) + degree;
  end

  assign valid_next = (note_next != 5'd0) && (note_next != note);

  always_ff @(posedge clk) begin
    if (rst) begin
      octave     <= '0;
      note       <= '0;
      note_valid <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      octave     <= octave_next;
      note       <= note_next;
      note_valid <= valid_next;
      key_err    <= multi;
    end
  end

endmodule

// File: tb/tb_button_to_note.sv
// tb/tb_button_to_note.sv - self-checking bench for button_to_note
module tb_button_to_note;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] key;
  logic       oct_up;
  logic       oct_dn;
  logic [4:0] note;
  logic       note_valid;
  logic [1:0] octave;
  logic       key_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] note;
    logic       valid;
  } ev_t;

  ev_t        sb [$];
  ev_t        ev;
  logic [4:0] prev_note = '0;
  bit         mon_en    = 1'b0;

  always #5 clk = ~clk;

  button_to_note #(
    .DEBOUNCE_CYCLES(4),
    .DB_CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .oct_up    (oct_up),
    .oct_dn    (oct_dn),
    .note      (note),
    .note_valid(note_valid),
    .octave    (octave),
    .key_err   (key_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [4:0] n, input logic v);
    ev_t e;
    e.note  = n;
    e.valid = v;
    sb.push_back(e);
  endtask

  task automatic wait_note(input logic [4:0] exp, input logic expv, input string tag);
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (note === exp) break;
    end
    check({tag, "_note"}, note, exp);
    check({tag, "_valid"}, note_valid, expv);
  endtask

  task automatic press_oct(input bit up, input logic [1:0] exp_oct, input string tag);
    if (up) oct_up = 1'b1; else oct_dn = 1'b1;
    step(8);
    check(tag, octave, exp_oct);
    oct_up = 1'b0;
    oct_dn = 1'b0;
    step(8);
  endtask

  // Every note change is matched against the next queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (note !== prev_note) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_change", note, prev_note);
        end else begin
          ev = sb.pop_front();
          check("sb_note", note, ev.note);
          check("sb_valid", note_valid, ev.valid);
        end
      end else begin
        check("sb_no_spurious_valid", note_valid, 0);
      end
      prev_note = note;
    end
  end

  initial begin
    rst    = 1'b1;
    key    = 7'b0000001;
    oct_up = 1'b1;
    oct_dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_note", note, 0);
      check("rst_octave", octave, 0);
      check("rst_valid", note_valid, 0);
      check("rst_key_err", key_err, 0);
    end
    rst    = 1'b0;
    key    = '0;
    oct_up = 1'b0;
    step(1);
    check("post_rst_note", note, 0);
    check("post_rst_octave", octave, 0);
    check("post_rst_valid", note_valid, 0);
    check("post_rst_key_err", key_err, 0);
    step(5);
    prev_note = note;
    mon_en    = 1'b1;

    key = 7'b0000001;
    push(5'd1, 1'b1);
    step(6);
    check("press_lat_pre", note, 0);
    step(1);
    check("press_note", note, 1);
    check("press_valid", note_valid, 1);
    step(1);
    check("press_valid_clear", note_valid, 0);
    step(12);
    key = '0;
    push(5'd0, 1'b0);
    step(6);
    check("release_lat_pre", note, 1);
    step(1);
    check("release_note", note, 0);
    check("release_valid", note_valid, 0);
    step(4);

    press_oct(1'b1, 2'd1, "oct_up1");
    press_oct(1'b1, 2'd2, "oct_up2");
    press_oct(1'b1, 2'd3, "oct_up3");
    press_oct(1'b1, 2'd3, "oct_up_sat");
    key = 7'b1000000;
    push(5'd28, 1'b1);
    wait_note(5'd28, 1'b1, "top_note");
    step(1);
    check("top_valid_clear", note_valid, 0);
    key = '0;
    push(5'd0, 1'b0);
    wait_note(5'd0, 1'b0, "top_release");
    step(4);
    press_oct(1'b0, 2'd2, "oct_dn1");
    press_oct(1'b0, 2'd1, "oct_dn2");
    press_oct(1'b0, 2'd0, "oct_dn3");
    press_oct(1'b0, 2'd0, "oct_dn_sat1");
    press_oct(1'b0, 2'd0, "oct_dn_sat2");

    key = 7'b0000100;
    step(3);
    key = '0;
    step(12);
    check("glitch_note", note, 0);
    key = 7'b0000100;
    push(5'd3, 1'b1);
    wait_note(5'd3, 1'b1, "deg3");
    key = '0;
    push(5'd0, 1'b0);
    wait_note(5'd0, 1'b0, "deg3_release");
    step(4);

    key = 7'b0001010;
    step(8);
    check("multi_key_err", key_err, 1);
    check("multi_note", note, 0);
    key = '0;
    step(8);
    check("multi_clear_err", key_err, 0);

    press_oct(1'b1, 2'd1, "hold_oct1");
    key = 7'b0010000;
    push(5'd12, 1'b1);
    wait_note(5'd12, 1'b1, "held_oct1");
    push(5'd5, 1'b1);
    oct_dn = 1'b1;
    wait_note(5'd5, 1'b1, "held_dn");
    step(1);
    check("held_dn_valid_clear", note_valid, 0);
    check("held_dn_octave", octave, 0);
    oct_dn = 1'b0;
    step(8);
    push(5'd12, 1'b1);
    oct_up = 1'b1;
    wait_note(5'd12, 1'b1, "held_up");
    oct_up = 1'b0;
    step(8);
    oct_up = 1'b1;
    oct_dn = 1'b1;
    step(10);
    check("both_octave", octave, 1);
    check("both_note", note, 12);
    oct_up = 1'b0;
    oct_dn = 1'b0;
    step(10);
    check("both_release_octave", octave, 1);
    key = '0;
    push(5'd0, 1'b0);
    wait_note(5'd0, 1'b0, "held_release");
    press_oct(1'b0, 2'd0, "back_oct0");

    key = 7'b0000001;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    push(5'd1, 1'b1);
    step(6);
    check("midrst_pre", note, 0);
    step(1);
    check("midrst_note", note, 1);
    check("midrst_valid", note_valid, 1);
    key = '0;
    push(5'd0, 1'b0);
    wait_note(5'd0, 1'b0, "midrst_release");
    step(4);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
